// File: rtl/multi_way_traffic_controller.sv
// multi_way_traffic_controller: round-robin, demand-driven signal controller for NUM_ROADS approaches.
// Define TRAFFIC_ALLRED_EN to insert an all-red clearance phase between YELLOW and the next GREEN.
module multi_way_traffic_controller #(
  parameter int NUM_ROADS   = 3,
  parameter int GREEN_TIME  = 15,
  parameter int YELLOW_TIME = 10,
  parameter int ALLRED_TIME = 2,
  parameter int TW          = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_ROADS-1:0]   demand,
  output logic [3*NUM_ROADS-1:0] lights,
  output logic [2:0]             active_road,
  output logic [1:0]             phase
);
  typedef enum logic [1:0] {GREEN = 2'd0, YELLOW = 2'd1, ALLRED = 2'd2} phase_e;
  localparam logic [3*NUM_ROADS-1:0] RST_LIGHTS = {{(NUM_ROADS-1){3'b100}}, 3'b001};
  phase_e                 phase_q, phase_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [2:0]             road_q, road_d, nxt_road;
  logic [3*NUM_ROADS-1:0] lights_q, lights_d;
  logic [7:0]             dem8;
  logic                   any_other;
  logic [3:0]             s;
  assign dem8      = 8'(demand);
  assign any_other = |(dem8 & ~(8'd1 << road_q));
  // Descending search so the nearest road after road_q wins.
  always_comb begin
    s = 4'd0;
    nxt_road = (road_q == 3'(NUM_ROADS-1)) ? 3'd0 : road_q + 3'd1;
    for (int k = NUM_ROADS-1; k >= 1; k--) begin
      s = {1'b0, road_q} + 4'(k);
      s = (s >= 4'(NUM_ROADS)) ? s - 4'(NUM_ROADS) : s;
      if (dem8[s[2:0]]) nxt_road = s[2:0];
    end
  end
  always_comb begin
    phase_d = phase_q;
    road_d  = road_q;
    timer_d = timer_q + TW'(1);
    case (phase_q)
      GREEN: if (timer_q == TW'(GREEN_TIME-1)) begin
        timer_d = '0;
        phase_d = any_other ? YELLOW : GREEN;
      end
      YELLOW: if (timer_q == TW'(YELLOW_TIME-1)) begin
        timer_d = '0;
`ifdef TRAFFIC_ALLRED_EN
        phase_d = ALLRED;
`else
        phase_d = GREEN;
        road_d  = nxt_road;
`endif
      end
`ifdef TRAFFIC_ALLRED_EN
      ALLRED: if (timer_q == TW'(ALLRED_TIME-1)) begin
        timer_d = '0;
        phase_d = GREEN;
        road_d  = nxt_road;
      end
`endif
      default: begin
        timer_d = '0;
        phase_d = GREEN;
      end
    endcase
    lights_d = '0;
    for (int i = 0; i < NUM_ROADS; i++)
      lights_d[3*i +: 3] = (road_d != 3'(i)) ? 3'b100 :
                           (phase_d == GREEN) ? 3'b001 :
                           (phase_d == YELLOW) ? 3'b010 : 3'b100;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= GREEN;
      timer_q  <= '0;
      road_q   <= 3'd0;
      lights_q <= RST_LIGHTS;
    end else begin
      phase_q  <= phase_d;
      timer_q  <= timer_d;
      road_q   <= road_d;
      lights_q <= lights_d;
    end
  end
  assign lights      = lights_q;
  assign active_road = road_q;
  assign phase       = phase_q;
endmodule

// File: tb/tb_multi_way_traffic_controller.sv
// tb_multi_way_traffic_controller: directed checks of phase sequencing, road selection and reset.
module tb_multi_way_traffic_controller;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] demand = 3'b000;
  logic [8:0] lights;
  logic [2:0] active_road;
  logic [1:0] phase;
  int         n_chk = 0;
  int         n_fail = 0;
`ifdef TRAFFIC_ALLRED_EN
  localparam int AR = 1;
`else
  localparam int AR = 0;
`endif
  multi_way_traffic_controller #(
    .NUM_ROADS(3), .GREEN_TIME(4), .YELLOW_TIME(2), .ALLRED_TIME(1), .TW(8)
  ) dut (
    .clk(clk), .rst(rst), .demand(demand),
    .lights(lights), .active_road(active_road), .phase(phase)
  );
  always #5 clk = ~clk;
  function automatic logic [8:0] exp_lights(input logic [1:0] ph, input logic [2:0] rd);
    logic [8:0] l;
    l = 9'b100_100_100;
    if (ph != 2'd2) l[3*rd +: 3] = (ph == 2'd0) ? 3'b001 : 3'b010;
    return l;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input logic [1:0] ph, input logic [2:0] rd, input string tag);
    n_chk++;
    assert (phase === ph) else begin
      n_fail++;
      $error("FAIL %s phase: observed %0d expected %0d", tag, phase, ph);
    end
    n_chk++;
    assert (active_road === rd) else begin
      n_fail++;
      $error("FAIL %s active_road: observed %0d expected %0d", tag, active_road, rd);
    end
    n_chk++;
    assert (lights === exp_lights(ph, rd)) else begin
      n_fail++;
      $error("FAIL %s lights: observed %b expected %b", tag, lights, exp_lights(ph, rd));
    end
  endtask
  task automatic run(input int n, input logic [1:0] ph, input logic [2:0] rd, input string tag);
    for (int c = 0; c < n; c++) begin
      step();
      chk(ph, rd, tag);
    end
  endtask
  task automatic do_reset(input logic [2:0] d, input string tag);
    rst = 1'b1;
    demand = d;
    step();
    rst = 1'b0;
    chk(2'd0, 3'd0, tag);
  endtask
  initial begin
    do_reset(3'b111, "reset");
    run(3, 0, 0, "rr_g0");
    run(2, 1, 0, "rr_y0");
    run(AR, 2, 0, "rr_a0");
    run(4, 0, 1, "rr_g1");
    run(2, 1, 1, "rr_y1");
    run(AR, 2, 1, "rr_a1");
    run(4, 0, 2, "rr_g2");
    run(2, 1, 2, "rr_y2");
    run(AR, 2, 2, "rr_a2");
    run(1, 0, 0, "rr_wrap");
    do_reset(3'b001, "reset_ext");
    run(12, 0, 0, "extend");
    do_reset(3'b100, "reset_skip");
    run(3, 0, 0, "skip_g0");
    run(2, 1, 0, "skip_y0");
    run(AR, 2, 0, "skip_a0");
    run(1, 0, 2, "skip_to2");
    demand = 3'b011;
    run(3, 0, 2, "wrap_g2");
    run(2, 1, 2, "wrap_y2");
    run(AR, 2, 2, "wrap_a2");
    run(1, 0, 0, "wrap_to0");
    run(3, 0, 0, "drop_g0");
    run(2, 1, 0, "drop_y0");
    run(AR, 2, 0, "drop_a0");
    run(1, 0, 1, "drop_to1");
    run(3, 0, 1, "drop_g1");
    run(1, 1, 1, "drop_y1a");
    demand = 3'b000;
    run(1, 1, 1, "drop_y1b");
    run(AR, 2, 1, "drop_a1");
    run(1, 0, 2, "drop_to2");
    run(6, 0, 2, "idle_hold");
    do_reset(3'b111, "reset_mid");
    run(3, 0, 0, "mid_g0");
    run(2, 1, 0, "mid_y0");
    run(AR, 2, 0, "mid_a0");
    run(4, 0, 1, "mid_g1");
    run(1, 1, 1, "mid_y1");
    do_reset(3'b111, "mid_reset");
    run(3, 0, 0, "post_g0");
    run(1, 1, 0, "post_y0");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/multi_way_traffic_controller.md
MULTI_WAY_TRAFFIC_CONTROLLER -- requirements
Module: multi_way_traffic_controller

Interface
REQ-001 Parameter NUM_ROADS, default 3: number of approach roads, legal range 2..8.
REQ-002 Parameter GREEN_TIME, default 15: green duration in clk cycles, legal range 1..2^TW-1.
REQ-003 Parameter YELLOW_TIME, default 10: yellow duration in clk cycles, legal range 1..2^TW-1.
REQ-004 Parameter ALLRED_TIME, default 2: all-red clearance duration in clk cycles, legal range 1..2^TW-1.
REQ-005 Parameter TW, default 8: phase timer width in bits.
REQ-006 clk  input  1: single clock; all state changes on its rising edge.
REQ-007 rst  input  1: reset, synchronous and active-high.
REQ-008 demand  input  NUM_ROADS: bit i high means a vehicle is waiting on road i; level-sensitive, sampled every cycle.
REQ-009 lights  output  3*NUM_ROADS: road i occupies bits [3i+2:3i]; 3'b001 is green, 3'b010 is yellow, 3'b100 is red.
REQ-010 active_road  output  3: index of the road currently holding right-of-way.
REQ-011 phase  output  2: 2'd0 is GREEN, 2'd1 is YELLOW, 2'd2 is ALLRED; 2'd3 is never driven.

Function
REQ-012 Phase FSM states: GREEN, YELLOW, ALLRED; ALLRED exists only per REQ-027.
REQ-013 A single TW-bit timer counts up by 1 each cycle within a phase and clears to 0 on every phase change.
REQ-014 lights, active_road and phase are registered and update in the same cycle as the FSM state; there is no extra output latency.
REQ-015 In GREEN, road active_road is 001 and all other roads are 100.
REQ-016 In YELLOW, road active_road is 010 and all other roads are 100.
REQ-017 In ALLRED, all roads are 100.
REQ-018 GREEN expires when timer==GREEN_TIME-1: the phase goes to YELLOW if any demand bit other than active_road is high.
REQ-019 If no other road's demand bit is high at GREEN expiry, the phase stays GREEN and the timer reloads to 0 (green extension, unbounded).
REQ-020 YELLOW expires when timer==YELLOW_TIME-1; a yellow phase always runs its full length once entered.
REQ-021 At the hand-over cycle, the next road is the first index with demand high, searching circularly from active_road+1; active_road itself is excluded.
REQ-022 If no demand bit is high at the hand-over cycle, the next road is (active_road+1) mod NUM_ROADS.
REQ-023 active_road wraps from NUM_ROADS-1 to 0; it never holds a value of NUM_ROADS or above.
REQ-024 No two roads are ever non-red in the same cycle; exactly one road is non-red in GREEN and YELLOW.
REQ-025 The timer never wraps; every expiry comparison is an equality test at TW bits.

Reset
REQ-026 While rst is high at a clk edge, the block loads: phase=GREEN, active_road=0, timer=0, lights road 0=001 and all others=100. This holds mid-phase as well, and the first GREEN after reset lasts the full GREEN_TIME.

Configuration
REQ-027 Macro TRAFFIC_ALLRED_EN.
- Defined: YELLOW expiry enters ALLRED for ALLRED_TIME cycles; the next road is chosen at ALLRED expiry (the hand-over cycle), which then enters GREEN.
- Undefined: YELLOW expiry goes directly to GREEN of the next road (the hand-over cycle is YELLOW expiry); ALLRED_TIME is ignored and phase never equals 2'd2.

Verification (NUM_ROADS=3, GREEN_TIME=4, YELLOW_TIME=2, ALLRED_TIME=1, TW=8)
REQ-028 Reset, then demand=3'b111 held: road0 green for 4 cycles, yellow for 2, then (with macro) all-red for 1, then road1 green; the sequence cycles 0,1,2,0 with lights one-hot per road every cycle.
REQ-029 demand=3'b001 constant after reset: road0 stays 001 indefinitely, timer reloads every 4 cycles, and phase stays 0.
REQ-030 active_road=0 with demand=3'b100: after green and yellow, road2 receives green and road1 is skipped.
REQ-031 active_road=2 with demand=3'b011: the next green goes to road0 (wrap-around).
REQ-032 demand drops to 3'b000 during YELLOW of road1: road2 receives green next (default rotation).
REQ-033 rst asserted for one cycle in the middle of road1 YELLOW: on the next edge lights=9'b100_100_001, active_road=0, phase=0, and the full 4-cycle green follows.
